// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for a common-anode hex display: shadowed value,
// fixed-rate digit slots, guard interval and optional leading-zero blanking.

module display_scan_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       upper_zero,
  output logic       zero_here
);
  // This digit and everything above it are zero with no decimal point.
  assign zero_here = upper_zero & ~|nib & ~dp;
endmodule

module display_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lz_en,
  output logic [3:0]                    digit,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] slot_idx
);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int TW = $clog2(REFRESH_DIV);

  logic [TW-1:0]                 tick_cnt;
  logic [NUM_DIGITS-1:0][3:0]    shadow_val;
  logic [NUM_DIGITS-1:0]         shadow_dp;
  logic [NUM_DIGITS:1]           zchain;
  logic [NUM_DIGITS-1:0]         blank;
  logic                          in_guard;
  logic                          an_on;
  logic [3:0]                    digit_nxt;
  logic [NUM_DIGITS-1:0]         an_nxt;
  logic                          dp_nxt;

  // Digit 0 never blanks, so the zero chain only spans digits 1..N-1.
  assign zchain[NUM_DIGITS] = 1'b1;
  assign blank[0]           = 1'b0;

  genvar k;
  generate
    for (k = 1; k < NUM_DIGITS; k++) begin : g_lane
      display_scan_lane u_lane (
        .nib        (shadow_val[k]),
        .dp         (shadow_dp[k]),
        .upper_zero (zchain[k+1]),
        .zero_here  (zchain[k])
      );
      assign blank[k] = lz_en & zchain[k];
    end
    if (GUARD == 0) begin : g_noguard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = tick_cnt < TW'(GUARD);
    end
  endgenerate

  always_comb begin
    an_nxt    = '1;
    digit_nxt = shadow_val[slot_idx];
    an_on     = !in_guard && !blank[slot_idx];
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_on && slot_idx == SW'(i)) an_nxt[i] = 1'b0;
    dp_nxt    = !(an_on && shadow_dp[slot_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt   <= '0;
      slot_idx   <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      digit      <= '0;
      an_n       <= '1;
      dp_n       <= 1'b1;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (tick_cnt == TW'(REFRESH_DIV-1)) begin
        tick_cnt <= '0;
        slot_idx <= (slot_idx == SW'(NUM_DIGITS-1)) ? '0 : slot_idx + SW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
      // Outputs are built from pre-edge state, so they trail the counter by one cycle.
      digit <= digit_nxt;
      an_n  <= an_nxt;
      dp_n  <= dp_nxt;
    end
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: position-based reference model checked every
// cycle, plus directed vectors with literal expectations.

module tb_display_scan_mux;
  localparam int N  = 4;
  localparam int RD = 4;
  localparam int GD = 1;

  logic        clk, rst, load, lz_en, dp_n;
  logic [15:0] value;
  logic [3:0]  dp_in, digit, an_n;
  logic [1:0]  slot_idx;

  display_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .lz_en(lz_en), .digit(digit), .an_n(an_n), .dp_n(dp_n), .slot_idx(slot_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: scan position is just cycles since reset release.
  int          pos;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  e_digit, e_an;
  logic        e_dp;
  logic [1:0]  e_slot;

  always @(posedge clk) begin
    int  slot, tk;
    logic blank, on;
    if (rst) begin
      pos = 0; m_val = '0; m_dp = '0;
      e_digit = '0; e_an = 4'hF; e_dp = 1'b1;
    end else begin
      slot    = (pos / RD) % N;
      tk      = pos % RD;
      e_digit = m_val[slot*4 +: 4];
      blank   = lz_en && slot > 0 && (m_val >> (4*slot)) == 16'h0 && (m_dp >> slot) == 4'h0;
      on      = tk >= GD && !blank;
      e_an    = on ? ~(4'b0001 << slot) : 4'hF;
      e_dp    = on ? ~m_dp[slot] : 1'b1;
      pos++;
      if (load) begin m_val = value; m_dp = dp_in; end
    end
    e_slot = 2'((pos / RD) % N);
  end

  always @(negedge clk) if (chk_en) begin
    chk("model_slot",  {30'd0, slot_idx}, {30'd0, e_slot});
    chk("model_digit", {28'd0, digit},    {28'd0, e_digit});
    chk("model_an",    {28'd0, an_n},     {28'd0, e_an});
    chk("model_dp",    {31'd0, dp_n},     {31'd0, e_dp});
    chk("onecold",     {31'd0, ($countones(~an_n) <= 1)}, 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reset, then load on the first free edge; returns with scan position 1.
  task automatic load_start(input logic [15:0] v, input logic [3:0] d, input logic lz);
    rst = 1; tick(1);
    rst = 0; load = 1; value = v; dp_in = d; lz_en = lz;
    tick(1);
    load = 0; value = 16'hDEAD;
  endtask

  task automatic run16(input string nm, input logic [3:0] ea[16], input logic [3:0] ed[16],
                       input logic [0:15] edp);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk({nm, "_an"},  {28'd0, an_n},  {28'd0, ea[i]});
      chk({nm, "_dig"}, {28'd0, digit}, {28'd0, ed[i]});
      chk({nm, "_dp"},  {31'd0, dp_n},  {31'd0, edp[i]});
    end
  endtask

  initial begin
    rst = 1; load = 0; value = '0; dp_in = '0; lz_en = 0;
    tick(1);
    chk_en = 1;
    for (int i = 0; i < 10; i++) begin
      load = 1; value = 16'hFFFF;  // load under reset must be ignored
      chk("rst_an", {28'd0, an_n}, 32'hF);
      chk("rst_dp", {31'd0, dp_n}, 32'd1);
      chk("rst_dig", {28'd0, digit}, 32'd0);
      chk("rst_slot", {30'd0, slot_idx}, 32'd0);
      tick(1);
    end
    load = 0;

    // Basic scan of 1A2F
    load_start(16'h1A2F, 4'h0, 1'b0);
    chk("scan_first_an", {28'd0, an_n}, 32'hF);
    chk("scan_first_dig", {28'd0, digit}, 32'd0);
    run16("scan",
      '{4'hE,4'hE,4'hE,4'hF, 4'hD,4'hD,4'hD,4'hF, 4'hB,4'hB,4'hB,4'hF, 4'h7,4'h7,4'h7,4'hF},
      '{4'hF,4'hF,4'hF,4'h2, 4'h2,4'h2,4'h2,4'hA, 4'hA,4'hA,4'hA,4'h1, 4'h1,4'h1,4'h1,4'hF},
      16'hFFFF);

    // Load after reset-held load: shadow must still be zero
    rst = 1; load = 1; value = 16'h7777; tick(1);
    load = 0; rst = 0; tick(2);
    chk("rstload_dig", {28'd0, digit}, 32'd0);
    chk("rstload_an", {28'd0, an_n}, 32'hE);

    // Mid-slot load at tick 2 of slot 0
    rst = 1; tick(1);
    rst = 0; tick(2);
    load = 1; value = 16'h0005; tick(1);
    load = 0;
    chk("mid_dig_old", {28'd0, digit}, 32'd0);
    chk("mid_slot0", {30'd0, slot_idx}, 32'd0);
    tick(1);
    chk("mid_dig_new", {28'd0, digit}, 32'd5);
    chk("mid_an", {28'd0, an_n}, 32'hE);
    chk("mid_slot1", {30'd0, slot_idx}, 32'd1);

    // Leading-zero blanking
    load_start(16'h0040, 4'h0, 1'b1);
    run16("lz40",
      '{4'hE,4'hE,4'hE,4'hF, 4'hD,4'hD,4'hD,4'hF, 4'hF,4'hF,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF},
      '{4'h0,4'h0,4'h0,4'h4, 4'h4,4'h4,4'h4,4'h0, 4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0},
      16'hFFFF);
    load_start(16'h0000, 4'h0, 1'b1);
    run16("lz00",
      '{4'hE,4'hE,4'hE,4'hF, 4'hF,4'hF,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF},
      '{4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0},
      16'hFFFF);
    load_start(16'h0040, 4'b0100, 1'b1);
    run16("lzdp",
      '{4'hE,4'hE,4'hE,4'hF, 4'hD,4'hD,4'hD,4'hF, 4'hB,4'hB,4'hB,4'hF, 4'hF,4'hF,4'hF,4'hF},
      '{4'h0,4'h0,4'h0,4'h4, 4'h4,4'h4,4'h4,4'h0, 4'h0,4'h0,4'h0,4'h0, 4'h0,4'h0,4'h0,4'h0},
      16'b1111_1111_0001_1111);

    // Reset mid-scan at slot 2, tick 3
    load_start(16'h1A2F, 4'hF, 1'b0);
    tick(10);
    chk("pre_rst_slot", {30'd0, slot_idx}, 32'd2);
    rst = 1; tick(1);
    chk("mrst_slot", {30'd0, slot_idx}, 32'd0);
    chk("mrst_an", {28'd0, an_n}, 32'hF);
    chk("mrst_dig", {28'd0, digit}, 32'd0);
    rst = 0; tick(2);
    chk("mrst_restart_an", {28'd0, an_n}, 32'hE);
    chk("mrst_shadow_clr", {28'd0, digit}, 32'd0);
    chk("mrst_dp_clr", {31'd0, dp_n}, 32'd1);

    // Load coincident with slot wrap
    load_start(16'h1A2F, 4'h0, 1'b0);
    tick(2);
    load = 1; value = 16'hBCDE; tick(1);
    load = 0;
    chk("wrap_old_dig", {28'd0, digit}, 32'hF);
    tick(1);
    chk("wrap_guard_an", {28'd0, an_n}, 32'hF);
    tick(1);
    chk("wrap_new_dig", {28'd0, digit}, 32'hD);
    chk("wrap_new_an", {28'd0, an_n}, 32'hD);
    tick(12);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
